mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM register and the MEM/WB register, and runs every load and store over a request/acknowledge data bus. While a transaction is outstanding it stalls the pipeline. It sign- or zero-extends load data and delivers it as `read_data`, the memory read-data field of the MEM/WB register.

---
 rtl/mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage pipeline; runs loads/stores over a req/ack data bus and stalls while busy.
// Build option: define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning them.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        reg_write_in,
  output logic        stall_out,
  output logic        reg_write_out,
  output logic [31:0] read_data_out,
  output logic        fault_out,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  input  logic        dbus_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        mem_op, bad_access, misaligned, timeout;
  logic [16:0] cnt_inc;

  function automatic logic access_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = is_load;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   res = {4{wd[7:0]}};
      2'b01:   res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = 32'(b);
      3'b100:  res = {24'd0, b};
      3'b001:  res = 32'(h);
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                      ((funct3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign mem_op     = mem_read_in | mem_write_in;
  assign bad_access = !access_legal(mem_read_in, funct3_in) || misaligned;
  assign cnt_inc    = {1'b0, cnt_q} + 17'd1;
  assign timeout    = cnt_inc >= 17'(TIMEOUT_CYCLES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_op && bad_access) begin
          state_d = DONE;
          fault_d = 1'b1;
          rdata_d = '0;
        end else if (mem_op) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = mem_write_in;
          addr_d  = {addr_in[31:2], 2'b00};
          wdata_d = store_lanes(funct3_in, wdata_in);
          be_d    = lane_enables(funct3_in, addr_in[1:0]);
          f3_d    = funct3_in;
          off_d   = addr_in[1:0];
        end
      end
      ACCESS: begin
        cnt_d = cnt_inc[15:0];
        // Error beats ack; an ack on the last allowed cycle still completes normally.
        if (dbus_err || (!dbus_ack && timeout)) begin
          state_d = DONE;
          req_d   = 1'b0;
          fault_d = 1'b1;
          rdata_d = '0;
        end else if (dbus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = load_extend(f3_q, off_q, dbus_rdata);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  // Gating by rst keeps the combinational outputs at 0 for as long as reset is held.
  assign stall_out     = !rst && (((state_q == IDLE) && mem_op) || (state_q == ACCESS));
  assign reg_write_out = !rst && reg_write_in && !stall_out && !fault_q;
  assign fault_out     = fault_q;
  assign read_data_out = rdata_q;
  assign dbus_req      = req_q;
  assign dbus_we       = we_q;
  assign dbus_addr     = addr_q;
  assign dbus_wdata    = wdata_q;
  assign dbus_be       = be_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in, reg_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall_out, reg_write_out, fault_out;
  logic [31:0] read_data_out;
  logic        dbus_req, dbus_we, dbus_ack, dbus_err;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_model;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .reg_write_in(reg_write_in),
    .stall_out(stall_out), .reg_write_out(reg_write_out),
    .read_data_out(read_data_out), .fault_out(fault_out),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .dbus_err(dbus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    longint v;
    case (f3)
      3'd0, 3'd4: begin
        v = longint'((w >> (8 * off)) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic bit model_bad(input bit rd, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    bit mis;
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = ((f3 % 4 == 1) && (a % 2 != 0)) || ((f3 % 4 == 2) && (a % 4 != 0));
`else
    if (a == 32'hFFFF_FFFF) mis = 1'b0;
`endif
    return !legal || mis;
  endfunction

  task automatic idle_instr(input bit rw);
    @(posedge clk); #1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = rw;
    dbus_ack = 1'b0; dbus_err = 1'b0;
    #3;
    check_eq("pass_stall", 32'(stall_out), 32'd0);
    check_eq("pass_rw", 32'(reg_write_out), 32'(rw));
    check_eq("pass_req", 32'(dbus_req), 32'd0);
    check_eq("pass_rdata", read_data_out, rd_model);
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit rw, input int waits,
                       input bit ackf, input bit errf, input logic [31:0] rdat);
    int          k, exp_n, stalls, off;
    bit          bad, flt, done;
    logic [31:0] e_be, e_wd, e_rd;
    off = int'(a % 4);
    bad = model_bad(rd, f3, a);
    case (f3 % 4)
      0:       begin e_be = 32'd1 << off; e_wd = (wd & 32'hFF) * 32'h0101_0101; end
      1:       begin e_be = (off >= 2) ? 32'hC : 32'h3; e_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
      default: begin e_be = 32'hF; e_wd = wd; end
    endcase
    if (bad) begin
      exp_n = 0; flt = 1'b1;
    end else if ((ackf || errf) && (waits + 1 <= TO)) begin
      exp_n = waits + 1; flt = errf;
    end else begin
      exp_n = TO; flt = 1'b1;
    end
    if (flt)     e_rd = 32'd0;
    else if (rd) e_rd = model_load(f3, off, rdat);
    else         e_rd = rd_model;

    @(posedge clk); #1;
    mem_read_in = rd; mem_write_in = wr; funct3_in = f3; addr_in = a; wdata_in = wd;
    reg_write_in = rw; dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = rdat;
    #3;
    check_eq("idle_stall", 32'(stall_out), 32'd1);
    check_eq("idle_req", 32'(dbus_req), 32'd0);
    check_eq("idle_rw", 32'(reg_write_out), 32'd0);
    stalls = 1; k = 0; done = 1'b0;
    for (int c = 0; c < TO + 4 && !done; c++) begin
      @(posedge clk); #1;
      if (dbus_req) begin
        k++;
        dbus_ack = ackf && (k == waits + 1);
        dbus_err = errf && (k == waits + 1);
        #3;
        if (stall_out) stalls++;
        check_eq("acc_we", 32'(dbus_we), 32'(wr));
        check_eq("acc_addr", dbus_addr, a & ~32'd3);
        check_eq("acc_be", 32'(dbus_be), e_be);
        if (wr) check_eq("acc_wdata", dbus_wdata, e_wd);
      end else begin
        dbus_ack = 1'b0; dbus_err = 1'b0;
        #3;
        done = 1'b1;
      end
    end
    check_eq("done_reached", 32'(done), 32'd1);
    check_eq("req_cycles", 32'(k), 32'(exp_n));
    check_eq("stall_cycles", 32'(stalls), 32'(exp_n + 1));
    check_eq("done_stall", 32'(stall_out), 32'd0);
    check_eq("done_fault", 32'(fault_out), 32'(flt));
    check_eq("done_rw", 32'(reg_write_out), 32'(rw && !flt));
    check_eq("done_rdata", read_data_out, e_rd);
    rd_model = e_rd;
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'd2; addr_in = 32'h40;
    reg_write_in = 1'b1; dbus_ack = 1'b0; dbus_err = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_pre_req", 32'(dbus_req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_req", 32'(dbus_req), 32'd0);
    check_eq("rst_stall", 32'(stall_out), 32'd0);
    check_eq("rst_rdata", read_data_out, 32'd0);
    check_eq("rst_rw", 32'(reg_write_out), 32'd0);
    mem_read_in = 1'b0; reg_write_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd_model = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'd2; addr_in = 32'h1234;
    wdata_in = 32'hFFFF_FFFF; reg_write_in = 1'b1;
    dbus_rdata = 32'h5555_AAAA; dbus_ack = 1'b1; dbus_err = 1'b0;
    rd_model = 32'd0;
    @(posedge clk); #3;
    check_eq("reset_stall", 32'(stall_out), 32'd0);
    check_eq("reset_rw", 32'(reg_write_out), 32'd0);
    check_eq("reset_rdata", read_data_out, 32'd0);
    check_eq("reset_fault", 32'(fault_out), 32'd0);
    check_eq("reset_req", 32'(dbus_req), 32'd0);
    check_eq("reset_we", 32'(dbus_we), 32'd0);
    check_eq("reset_addr", dbus_addr, 32'd0);
    check_eq("reset_wdata", dbus_wdata, 32'd0);
    check_eq("reset_be", 32'(dbus_be), 32'd0);
    mem_read_in = 1'b0; reg_write_in = 1'b0; dbus_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    idle_instr(1'b1);
    idle_instr(1'b0);
    do_op(1, 0, 3'd2, 32'h100, 32'd0, 1, 0, 1, 0, 32'hDEAD_BEEF);
    do_op(1, 0, 3'd0, 32'h103, 32'd0, 1, 0, 1, 0, 32'h80FF_FF7F);
    do_op(1, 0, 3'd4, 32'h103, 32'd0, 1, 0, 1, 0, 32'h80FF_FF7F);
    do_op(1, 0, 3'd1, 32'h102, 32'd0, 1, 1, 1, 0, 32'h9ABC_1234);
    do_op(1, 0, 3'd5, 32'h102, 32'd0, 1, 2, 1, 0, 32'h9ABC_1234);
    do_op(0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 0, 3, 1, 0, 32'd0);
    do_op(0, 1, 3'd0, 32'h201, 32'h0000_00A5, 0, 0, 1, 0, 32'd0);
    do_op(1, 0, 3'd2, 32'h300, 32'd0, 1, 0, 0, 0, 32'h1111_2222);
    do_op(1, 0, 3'd2, 32'h101, 32'd0, 1, 0, 1, 0, 32'h1122_3344);
    do_op(1, 0, 3'd2, 32'h104, 32'd0, 1, 1, 1, 1, 32'h7777_7777);
    do_op(1, 0, 3'd3, 32'h108, 32'd0, 1, 0, 1, 0, 32'h7777_7777);
    do_op(0, 1, 3'd4, 32'h10C, 32'h1, 0, 0, 1, 0, 32'd0);
    do_op(1, 0, 3'd2, 32'h400, 32'd0, 1, TO - 1, 1, 0, 32'hCAFE_F00D);
    reset_mid();
    idle_instr(1'b1);

    for (int i = 0; i < 300; i++) begin
      int          kind, resp, waits;
      bit          rd;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        idle_instr(1'($urandom_range(0, 1)));
      end else begin
        rd = (kind < 6);
        if ($urandom_range(0, 9) < 8) f3 = rd ? 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2)
                                              : 3'($urandom_range(0, 2));
        else f3 = 3'($urandom_range(0, 7));
        if (rd && f3 == 3'd6) f3 = 3'd2;
        a     = $urandom;
        resp  = int'($urandom_range(0, 9));
        waits = int'($urandom_range(0, 5));
        do_op(rd, !rd, f3, a, $urandom, 1'($urandom_range(0, 1)), waits,
              resp < 7 || resp == 8, resp == 7 || resp == 8, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
